gray_rd_arbiter: RTL

GRAY_RD_ARBITER -- requirements
Module: gray_rd_arbiter

---
 rtl/gray_rd_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gray_rd_arbiter.sv
// Two-requester read arbiter for a gray-image memory: round-robin with a bounded burst
// lock, and a fixed 3-cycle grant-to-data pipeline that routes data back to its owner.
module gray_rd_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [13:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [13:0] m1_addr,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [7:0]  m1_rdata,
    output logic        mem_en,
    output logic [13:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        dbg_state,
    output logic [3:0]  dbg_burst_cnt
);

    // Handshake: a requester holds mX_req (with lock/addr stable) until mX_gnt; the
    // read is accepted in the cycle where req && gnt, and data returns 3 cycles later
    // as a one-cycle mX_rvalid pulse with no back-pressure.

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_t;

    localparam logic [3:0] BURST_MAX = 4'd9;

    arb_state_t state_q, state_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       last_id_q, last_id_d;

    logic       gnt_any;
    logic       gnt_id;
    logic       gnt_lock;
    logic       other_req;
    logic [3:0] cnt_inc;

    logic       tag1_q;
    logic       v2_q;
    logic       tag2_q;

    function automatic arb_state_t pri_of(input logic id);
        return id ? PRI1 : PRI0;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PRI0;
            burst_cnt_q <= 4'd0;
            last_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = 4'd0;
        last_id_d   = last_id_q;
        gnt_any     = 1'b0;
        gnt_id      = 1'b0;
        gnt_lock    = 1'b0;
        other_req   = 1'b0;
        cnt_inc     = 4'd1;

        // Grants are suppressed entirely while reset is held.
        if (reset) begin
            gnt_any = m0_req | m1_req;
            if (m0_req && m1_req) begin
                gnt_id = (state_q == PRI1);
            end else begin
                gnt_id = m1_req;
            end
        end

        gnt_lock  = gnt_id ? m1_lock : m0_lock;
        other_req = gnt_id ? m0_req : m1_req;

        if (gnt_id == last_id_q) begin
            cnt_inc = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + 4'd1;
        end

        if (gnt_any) begin
            last_id_d = gnt_id;
            if (!gnt_lock) begin
                state_d = pri_of(~gnt_id);
            end else if (cnt_inc == BURST_MAX && other_req) begin
                // Burst limit reached with a waiting rival: hand priority over.
                state_d = pri_of(~gnt_id);
            end else begin
                state_d     = pri_of(gnt_id);
                burst_cnt_d = cnt_inc;
            end
        end
    end

    assign m0_gnt        = gnt_any & ~gnt_id;
    assign m1_gnt        = gnt_any & gnt_id;
    assign dbg_state     = state_q;
    assign dbg_burst_cnt = burst_cnt_q;

    // Stage 1 is mem_en/tag1, stage 2 is v2/tag2 (memory data present), stage 3 is rvalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_addr  <= 14'd0;
            tag1_q    <= 1'b0;
            v2_q      <= 1'b0;
            tag2_q    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 8'd0;
            m1_rdata  <= 8'd0;
            busy      <= 1'b0;
        end else begin
            mem_en <= gnt_any;
            if (gnt_any) begin
                mem_addr <= gnt_id ? m1_addr : m0_addr;
            end
            tag1_q    <= gnt_id;
            v2_q      <= mem_en;
            tag2_q    <= tag1_q;
            m0_rvalid <= v2_q & ~tag2_q;
            m1_rvalid <= v2_q & tag2_q;
            if (v2_q && !tag2_q) begin
                m0_rdata <= mem_rdata;
            end
            if (v2_q && tag2_q) begin
                m1_rdata <= mem_rdata;
            end
            busy <= gnt_any | mem_en | v2_q;
        end
    end

endmodule
